// File: rtl/bootstrap_loader.sv
// bootstrap_loader: writes a byte stream into the microcode LUT bootstrap port
// using a setup/strobe/hold write cycle, then drops N_BOOTED.
// Optional feature: define BOOTSTRAP_CHECKSUM_EN to accept a trailing checksum
// byte that must bring the mod-256 sum of all bytes to zero.
module bootstrap_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned COUNT      = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [ADDR_WIDTH-1:0] BOOTSTRAP_ADDR,
  output logic [7:0]            BOOTSTRAP_DATA,
  output logic                  BOOTSTRAP_N_WE,
  output logic                  N_BOOTED,
  output logic                  ERROR
);

  localparam int unsigned IDX_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

  logic [2:0]            state, state_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [7:0]            data_n;
  logic                  n_we_n;
  logic                  ready_n;
  logic                  n_booted_n;
  logic                  accept;

  assign accept = IN_VALID & IN_READY;

`ifdef BOOTSTRAP_CHECKSUM_EN
  logic [7:0] sum, sum_n;
  logic       error_n;
`endif

  // Next-state and next-output decode; every output is re-registered below.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    addr_n     = BOOTSTRAP_ADDR;
    data_n     = BOOTSTRAP_DATA;
    n_we_n     = 1'b1;
`ifdef BOOTSTRAP_CHECKSUM_EN
    sum_n      = sum;
`endif
    case (state)
      S_WAIT: begin
        if (accept) begin
          data_n  = IN_DATA;
          addr_n  = idx[ADDR_WIDTH-1:0];
`ifdef BOOTSTRAP_CHECKSUM_EN
          sum_n   = 8'(sum + IN_DATA);
`endif
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        n_we_n  = 1'b0;
        state_n = S_STROBE;
      end
      S_STROBE: state_n = S_HOLD;
      S_HOLD: begin
        idx_n = IDX_W'(idx + 1'b1);
        if (idx == LAST_IDX) begin
`ifdef BOOTSTRAP_CHECKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_WAIT;
        end
      end
`ifdef BOOTSTRAP_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          state_n = (8'(sum + IN_DATA) == 8'd0) ? S_DONE : S_FAIL;
        end
      end
`endif
      S_DONE, S_FAIL: state_n = state;
      default:        state_n = S_WAIT;
    endcase
    ready_n    = (state_n == S_WAIT) || (state_n == S_CHECK);
    n_booted_n = (state_n != S_DONE);
`ifdef BOOTSTRAP_CHECKSUM_EN
    error_n    = (state_n == S_FAIL);
`endif
  end

  // State, index and registered port outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= S_WAIT;
      idx            <= '0;
      BOOTSTRAP_ADDR <= '0;
      BOOTSTRAP_DATA <= 8'd0;
      BOOTSTRAP_N_WE <= 1'b1;
      IN_READY       <= 1'b0;
      N_BOOTED       <= 1'b1;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      BOOTSTRAP_ADDR <= addr_n;
      BOOTSTRAP_DATA <= data_n;
      BOOTSTRAP_N_WE <= n_we_n;
      IN_READY       <= ready_n;
      N_BOOTED       <= n_booted_n;
    end
  end

`ifdef BOOTSTRAP_CHECKSUM_EN
  // Running checksum and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum   <= 8'd0;
      ERROR <= 1'b0;
    end else begin
      sum   <= sum_n;
      ERROR <= error_n;
    end
  end
`else
  assign ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_bootstrap_loader.sv
// tb_bootstrap_loader: directed bench for bootstrap_loader with ADDR_WIDTH=2,
// COUNT=4, so the last write lands on the all-ones address.
module tb_bootstrap_loader;

  localparam int unsigned AW  = 2;
  localparam int unsigned CNT = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [7:0]    IN_DATA;
  logic          IN_VALID;
  logic          IN_READY;
  logic [AW-1:0] BOOTSTRAP_ADDR;
  logic [7:0]    BOOTSTRAP_DATA;
  logic          BOOTSTRAP_N_WE;
  logic          N_BOOTED;
  logic          ERROR;

  int  vectors     = 0;
  int  miscompares = 0;

  int            strobe_cnt = 0;
  logic [AW-1:0] s_addr [32];
  logic [7:0]    s_data [32];
  time           t_fall [32];
  time           t_rise [32];
  time           t_boot = 0;
  time           t_acc  = 0;
  time           t_acc0 = 0;
  int            sb;
  logic [7:0]    bytes_a [4];
  logic [7:0]    bytes_b [4];

  bootstrap_loader #(.ADDR_WIDTH(AW), .COUNT(CNT)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .BOOTSTRAP_ADDR(BOOTSTRAP_ADDR),
    .BOOTSTRAP_DATA(BOOTSTRAP_DATA), .BOOTSTRAP_N_WE(BOOTSTRAP_N_WE),
    .N_BOOTED(N_BOOTED), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  // Log every write strobe with the address/data present at its falling edge.
  always @(negedge BOOTSTRAP_N_WE) begin
    if (strobe_cnt < 32) begin
      s_addr[strobe_cnt] = BOOTSTRAP_ADDR;
      s_data[strobe_cnt] = BOOTSTRAP_DATA;
      t_fall[strobe_cnt] = $time;
    end
    strobe_cnt = strobe_cnt + 1;
  end

  always @(posedge BOOTSTRAP_N_WE) begin
    if (strobe_cnt > 0 && strobe_cnt <= 32) t_rise[strobe_cnt-1] = $time;
  end

  always @(negedge N_BOOTED) t_boot = $time;

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer a byte after 'gap' idle cycles; returns #1 after the accepting edge
  // with IN_VALID still high so the loader sees it during SETUP/STROBE/HOLD.
  task automatic send(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    IN_VALID = 1'b0;
    repeat (gap) tick();
    IN_DATA  = b;
    IN_VALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (IN_READY) begin
        @(posedge CLK);
        t_acc = $time;
        #1;
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input logic [7:0] exp_b [4]);
    chk({tag, "_strobe_count"}, 32'(strobe_cnt - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, 32'(s_addr[base+i]), 32'(i));
      chk({tag, "_data"}, 32'(s_data[base+i]), 32'(exp_b[i]));
      chk({tag, "_width"}, 32'(t_rise[base+i] - t_fall[base+i]), 32'd10);
    end
  endtask

  initial begin
    bytes_a[0] = 8'h11; bytes_a[1] = 8'h22; bytes_a[2] = 8'h33; bytes_a[3] = 8'h44;
    bytes_b[0] = 8'hC1; bytes_b[1] = 8'hC2; bytes_b[2] = 8'hC3; bytes_b[3] = 8'hC4;
    RST = 1'b1; IN_VALID = 1'b0; IN_DATA = 8'h00;
    repeat (2) tick();

    // Reset values.
    chk("rst_ready", 32'(IN_READY), 32'd0);
    chk("rst_addr", 32'(BOOTSTRAP_ADDR), 32'd0);
    chk("rst_data", 32'(BOOTSTRAP_DATA), 32'd0);
    chk("rst_nwe", 32'(BOOTSTRAP_N_WE), 32'd1);
    chk("rst_nbooted", 32'(N_BOOTED), 32'd1);
    chk("rst_error", 32'(ERROR), 32'd0);

    // IN_READY rises one cycle after release.
    RST = 1'b0;
    #1 chk("ready_before_edge", 32'(IN_READY), 32'd0);
    tick();
    chk("ready_after_edge", 32'(IN_READY), 32'd1);

    // Back-to-back load of 0x11..0x44.
    sb = strobe_cnt;
    send(bytes_a[0], 0);
    t_acc0 = t_acc;
    for (int i = 1; i < 4; i++) send(bytes_a[i], 0);
`ifdef BOOTSTRAP_CHECKSUM_EN
    send(8'h56, 0);
`endif
    IN_VALID = 1'b0;
    repeat (4) tick();
    check_writes("load1", sb, bytes_a);
    chk("load1_nbooted", 32'(N_BOOTED), 32'd0);
    chk("load1_error", 32'(ERROR), 32'd0);
    chk("load1_ready", 32'(IN_READY), 32'd0);
`ifndef BOOTSTRAP_CHECKSUM_EN
    // Accept edge is edge 1; N_BOOTED falls on edge 16, i.e. 15 periods later.
    chk("load1_boot_time", 32'(t_boot - t_acc0), 32'd150);
`endif

    // DONE is sticky and ignores further input.
    IN_DATA = 8'hFF; IN_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("done_ready", 32'(IN_READY), 32'd0);
      chk("done_nbooted", 32'(N_BOOTED), 32'd0);
    end
    chk("done_no_strobe", 32'(strobe_cnt - sb), 32'd4);
    IN_VALID = 1'b0;

    // Reset during the strobe of the second byte.
    RST = 1'b1;
    #1 chk("rst2_nbooted", 32'(N_BOOTED), 32'd1);
    tick();
    RST = 1'b0;
    tick();
    send(8'hA5, 0);
    send(8'h5A, 0);
    tick();
    chk("mid_strobe_low", 32'(BOOTSTRAP_N_WE), 32'd0);
    chk("mid_strobe_addr", 32'(BOOTSTRAP_ADDR), 32'd1);
    RST = 1'b1;
    #1;
    chk("async_nwe", 32'(BOOTSTRAP_N_WE), 32'd1);
    chk("async_addr", 32'(BOOTSTRAP_ADDR), 32'd0);
    chk("async_data", 32'(BOOTSTRAP_DATA), 32'd0);
    chk("async_ready", 32'(IN_READY), 32'd0);
    IN_VALID = 1'b0;
    tick();
    RST = 1'b0;
    tick();

    // Reload with gaps in IN_VALID; addresses restart at 0.
    sb = strobe_cnt;
    send(bytes_b[0], 0);
    send(bytes_b[1], 2);
    send(bytes_b[2], 1);
    send(bytes_b[3], 0);
`ifdef BOOTSTRAP_CHECKSUM_EN
    send(8'hF6, 1);
`endif
    IN_VALID = 1'b0;
    repeat (4) tick();
    check_writes("reload", sb, bytes_b);
    chk("reload_nbooted", 32'(N_BOOTED), 32'd0);

`ifdef BOOTSTRAP_CHECKSUM_EN
    // Wrong checksum lands in the sticky error state.
    RST = 1'b1; tick(); RST = 1'b0; tick();
    sb = strobe_cnt;
    for (int i = 0; i < 4; i++) send(bytes_a[i], 0);
    send(8'h57, 0);
    IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bad_sum_ready", 32'(IN_READY), 32'd0);
    end
    IN_VALID = 1'b0;
    chk("bad_sum_error", 32'(ERROR), 32'd1);
    chk("bad_sum_nbooted", 32'(N_BOOTED), 32'd1);
    chk("bad_sum_strobes", 32'(strobe_cnt - sb), 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
